// File: rtl/core_if_fetch_q_pkg.sv
// Shared widths, constants and helpers for the instruction-fetch queue.
// Global fetch defines live here so every file sees them after the package.
`ifndef CORE_DEFINES_VH
`define CORE_DEFINES_VH
`define XLEN 32
`define PC_START 32'h0000_0000
`define FQ_PC_W 32
`define FQ_INSTR_W 32
`endif

package core_if_fetch_q_pkg;

   localparam int PC_STEP      = 4;
   localparam int ENTRY_FIELDS = 3;
   localparam int PC_W         = `FQ_PC_W;
   localparam int INSTR_W      = `FQ_INSTR_W;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [PC_W-1:0]    pc_4;
      logic [INSTR_W-1:0] instr;
   } fq_entry_t;

   function automatic int entry_w(input int xlen);
      return ENTRY_FIELDS * xlen;
   endfunction

endpackage

// File: rtl/core_if_fetch_q_fifo.sv
// Synchronous FIFO with flush and occupancy count.
// Holds the {pc, pc_4, instr} entries waiting for decode.
module core_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic [W-1:0]               pop_data,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign do_pop   = pop & !empty;
   // a full queue may still take a push if the head leaves in the same cycle
   assign do_push  = push & (!full | do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/core_if_fetch_q.sv
// Instruction-fetch stage: sequential PC generation, L1I request channel,
// in-order response capture and a decoupled fetch queue towards decode.
module core_if_fetch_q
   import core_if_fetch_q_pkg::*;
#(
   parameter int               XLEN     = `XLEN,
   parameter int               FQ_DEPTH = 4,
   parameter int               MAX_OUT  = 2,
   parameter logic [XLEN-1:0]  PC_RESET = `PC_START
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_stop_in,
   input  logic            if_redirect_in,
   input  logic [XLEN-1:0] if_redirect_addr_in,
   output logic            l1i_req_val_out,
   input  logic            l1i_req_rdy_in,
   output logic [XLEN-1:0] l1i_req_addr_out,
   input  logic            l1i_resp_val_in,
   input  logic [XLEN-1:0] l1i_resp_data_in,
   output logic            dec_val_out,
   input  logic            dec_rdy_in,
   output logic [XLEN-1:0] dec_pc_out,
   output logic [XLEN-1:0] dec_pc_4_out,
   output logic [XLEN-1:0] dec_instr_out
);

   localparam int OW = $clog2(MAX_OUT+1);
   localparam int CW = $clog2(FQ_DEPTH+1);
   localparam int EW = entry_w(XLEN);
   localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

   logic [XLEN-1:0] pc_reg;
   logic [XLEN-1:0] resp_pc;
   logic [OW-1:0]   outstanding;
   logic [OW-1:0]   drop_cnt;
   logic [CW-1:0]   fq_count;
   logic            fq_empty;
   logic [EW-1:0]   push_data;
   logic [EW-1:0]   head;
   logic [31:0]     occ;
   logic            req_val;
   logic            accept;
   logic            resp_live;
   logic            push;
   logic            pop;

   // slots already promised: queued entries plus live in-flight fetches
   assign occ = 32'(fq_count) + 32'(outstanding) - 32'(drop_cnt);

   assign req_val = rst_n & !if_redirect_in & !if_stop_in
                  & (32'(outstanding) < 32'(MAX_OUT))
                  & (occ < 32'(FQ_DEPTH));

   assign accept    = req_val & l1i_req_rdy_in;
   assign resp_live = l1i_resp_val_in & (drop_cnt == '0);
   assign push      = resp_live & !if_redirect_in;
   assign pop       = !fq_empty & dec_rdy_in & !if_redirect_in;
   assign push_data = {resp_pc, resp_pc + STEP, l1i_resp_data_in};

   assign l1i_req_val_out  = req_val;
   assign l1i_req_addr_out = pc_reg;
   assign dec_val_out      = !fq_empty;
   assign {dec_pc_out, dec_pc_4_out, dec_instr_out} = head;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg <= PC_RESET;
      end else if (if_redirect_in) begin
         pc_reg <= if_redirect_addr_in;
      end else if (accept) begin
         pc_reg <= pc_reg + STEP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_pc <= PC_RESET;
      end else if (if_redirect_in) begin
         resp_pc <= if_redirect_addr_in;
      end else if (push) begin
         resp_pc <= resp_pc + STEP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= '0;
      end else if (if_redirect_in) begin
         outstanding <= outstanding - OW'(l1i_resp_val_in);
      end else begin
         outstanding <= outstanding + OW'(accept) - OW'(l1i_resp_val_in);
      end
   end

   // everything still in flight at a redirect belongs to the old stream
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (if_redirect_in) begin
         drop_cnt <= outstanding - OW'(l1i_resp_val_in);
      end else if (l1i_resp_val_in && drop_cnt != '0) begin
         drop_cnt <= drop_cnt - OW'(1);
      end
   end

   core_sync_fifo #(
      .W     (EW),
      .DEPTH (FQ_DEPTH)
   ) u_fq (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (if_redirect_in),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (head),
      .empty     (fq_empty),
      .count     (fq_count)
   );

endmodule

// File: tb/tb_core_if_fetch_q.sv
// Randomised bench for core_if_fetch_q against a queue-based fetch model.
module tb_core_if_fetch_q;

   localparam int          FQ_DEPTH = 4;
   localparam int          MAX_OUT  = 2;
   localparam logic [31:0] PC_RST   = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stop;
   logic        redir;
   logic [31:0] redir_addr;
   logic        req_val;
   logic        req_rdy;
   logic [31:0] req_addr;
   logic        resp_val;
   logic [31:0] resp_data;
   logic        dec_val;
   logic        dec_rdy;
   logic [31:0] dec_pc;
   logic [31:0] dec_pc_4;
   logic [31:0] dec_instr;

   typedef struct {
      logic [31:0] addr;
      bit          live;
   } fl_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } de_t;

   fl_t         inflight[$];
   de_t         dq[$];
   logic [31:0] model_pc;
   int          n_chk = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   core_if_fetch_q #(
      .XLEN     (32),
      .FQ_DEPTH (FQ_DEPTH),
      .MAX_OUT  (MAX_OUT),
      .PC_RESET (PC_RST)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .if_stop_in          (stop),
      .if_redirect_in      (redir),
      .if_redirect_addr_in (redir_addr),
      .l1i_req_val_out     (req_val),
      .l1i_req_rdy_in      (req_rdy),
      .l1i_req_addr_out    (req_addr),
      .l1i_resp_val_in     (resp_val),
      .l1i_resp_data_in    (resp_data),
      .dec_val_out         (dec_val),
      .dec_rdy_in          (dec_rdy),
      .dec_pc_out          (dec_pc),
      .dec_pc_4_out        (dec_pc_4),
      .dec_instr_out       (dec_instr)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      stop       = 1'b0;
      redir      = 1'b0;
      redir_addr = '0;
      req_rdy    = 1'b0;
      resp_val   = 1'b0;
      resp_data  = '0;
      dec_rdy    = 1'b0;
   endtask

   task automatic model_reset();
      inflight.delete();
      dq.delete();
      model_pc = PC_RST;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_val"}, 32'(req_val), 32'd0);
      check({tag, "_dec_val"}, 32'(dec_val), 32'd0);
   endtask

   function automatic logic [31:0] pick_addr();
      logic [31:0] a;
      case ($urandom_range(0, 5))
         0: a = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
         1: a = $urandom;
         default: a = {$urandom_range(0, 32'h3FFF), 2'b00};
      endcase
      return a;
   endfunction

   task automatic run_cycle(input int p_rdy, input int p_dec,
                            input int p_stop, input int p_redir,
                            input int p_resp);
      int  live;
      bit  exp_val;
      fl_t f;
      de_t e;
      @(negedge clk);
      req_rdy    = ($urandom_range(0, 99) < p_rdy);
      dec_rdy    = ($urandom_range(0, 99) < p_dec);
      stop       = ($urandom_range(0, 99) < p_stop);
      redir      = ($urandom_range(0, 99) < p_redir);
      redir_addr = pick_addr();
      resp_val   = (inflight.size() > 0) && ($urandom_range(0, 99) < p_resp);
      resp_data  = resp_val ? (inflight[0].addr ^ 32'hFFFF_FFFF) : $urandom;
      #1;
      live = 0;
      foreach (inflight[i]) if (inflight[i].live) live++;
      exp_val = !redir && !stop && (inflight.size() < MAX_OUT)
                && (dq.size() + live < FQ_DEPTH);
      check("req_val", 32'(req_val), 32'(exp_val));
      if (exp_val) check("req_addr", req_addr, model_pc);
      check("dec_val", 32'(dec_val), 32'(dq.size() != 0));
      if (dq.size() != 0) begin
         check("dec_pc", dec_pc, dq[0].pc);
         check("dec_pc_4", dec_pc_4, dq[0].pc + 32'd4);
         check("dec_instr", dec_instr, dq[0].instr);
      end
      @(posedge clk);
      if (redir) begin
         if (resp_val) void'(inflight.pop_front());
         foreach (inflight[i]) inflight[i].live = 1'b0;
         dq.delete();
         model_pc = redir_addr;
      end else begin
         if (dq.size() != 0 && dec_rdy) void'(dq.pop_front());
         if (resp_val) begin
            f = inflight.pop_front();
            if (f.live) begin
               e.pc    = f.addr;
               e.instr = resp_data;
               dq.push_back(e);
            end
         end
         if (exp_val && req_rdy) begin
            f.addr = model_pc;
            f.live = 1'b1;
            inflight.push_back(f);
            model_pc = model_pc + 32'd4;
         end
      end
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      #2;
      check_reset_outputs("rst");
      check("rst_dec_pc", dec_pc, 32'd0);
      check("rst_dec_instr", dec_instr, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // streaming, then backpressure, redirects, stalls and a mix
      repeat (200) run_cycle(100, 100, 0, 0, 100);
      repeat (300) run_cycle(100, 10, 0, 0, 80);
      repeat (400) run_cycle(80, 70, 0, 12, 60);
      repeat (300) run_cycle(90, 80, 60, 3, 50);
      repeat (400) run_cycle(60, 50, 20, 8, 40);

      // asynchronous reset between clock edges, mid-stream
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      idle_inputs();
      #1;
      check_reset_outputs("mid_rst");
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      repeat (200) run_cycle(100, 100, 0, 0, 100);
      repeat (600) run_cycle(70, 60, 15, 10, 50);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
